axil_cpu_master: RTL

Bridge between the soft CPU's native memory port (valid/ready, byte strobes) and an AXI4-Lite master port. One CPU request becomes exactly one AXI-Lite read or write transaction. It sits directly upstream of the BRAM AXI-Lite memory, or of the interconnect in front of it, and is the only master on that bus.

---
 rtl/axil_pkg.sv | 20 ++
 rtl/axil_cpu_master.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the CPU-to-AXI4-Lite bridge.
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DONE
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_INSTR  = 3'b100;
    localparam logic [2:0] PROT_DATA   = 3'b000;

endpackage

// File: rtl/axil_cpu_master.sv
// Turns each CPU valid/ready request into exactly one AXI4-Lite read or write.
// mem_ready pulses one cycle after the final B/R handshake; valids hold until their own handshake.
module axil_cpu_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [STRB_WIDTH-1:0] mem_wstrb,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_error,
    output logic                  bus_error_seen,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  instr_q, instr_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [1:0]            resp_q, resp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_seen_q, err_seen_d;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            instr_q    <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            resp_q     <= RESP_OKAY;
            rdata_q    <= '0;
            err_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            instr_q    <= instr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            err_seen_q <= err_seen_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        instr_d        = instr_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        resp_d         = resp_q;
        rdata_d        = rdata_q;
        err_seen_d     = err_seen_q;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        mem_ready      = 1'b0;
        mem_error      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    state_d = (|mem_wstrb) ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                // AW and W retire independently; leave once both have handshaken
                m_axil_awvalid = !aw_done_q;
                m_axil_wvalid  = !w_done_q;
                if (!aw_done_q && m_axil_awready) aw_done_d = 1'b1;
                if (!w_done_q && m_axil_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)        state_d   = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                m_axil_bready = 1'b1;
                if (m_axil_bvalid) begin
                    resp_d  = m_axil_bresp;
                    state_d = ST_DONE;
                    if (m_axil_bresp != RESP_OKAY) err_seen_d = 1'b1;
                end
            end
            ST_RD_REQ: begin
                m_axil_arvalid = 1'b1;
                if (m_axil_arready) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                m_axil_rready = 1'b1;
                if (m_axil_rvalid) begin
                    rdata_d = m_axil_rdata;
                    resp_d  = m_axil_rresp;
                    state_d = ST_DONE;
                    if (m_axil_rresp != RESP_OKAY) err_seen_d = 1'b1;
                end
            end
            ST_DONE: begin
                // CPU drops mem_valid this cycle, so IDLE is entered without resampling it
                mem_ready = 1'b1;
                mem_error = (resp_q != RESP_OKAY);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_rdata      = rdata_q;
    assign bus_error_seen = err_seen_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = PROT_DATA;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = instr_q ? PROT_INSTR : PROT_DATA;

endmodule
